// File: rtl/tx_tlp_req_arbiter.sv
// TX TLP request arbiter: round-robin arbitration of chunk-read, notification
// and interrupt requesters onto the single TLP formatter port, with an
// outstanding-read credit counter that throttles chunk reads.
module tx_tlp_req_arbiter #(
    parameter int unsigned MAX_RD_OUTSTANDING = 8,
    parameter int unsigned CNT_W              = 4
) (
    input  logic             trn_clk,
    input  logic             reset_n,
    input  logic             rd_req,
    input  logic [63:0]      rd_addr,
    input  logic [8:0]       rd_qwords,
    output logic             rd_ack,
    input  logic             ntf_req,
    output logic             ntf_ack,
    input  logic             irq_req,
    output logic             irq_ack,
    output logic             tlp_start,
    output logic [1:0]       tlp_kind,
    output logic [63:0]      tlp_addr,
    output logic [8:0]       tlp_qwords,
    input  logic             tlp_start_ack,
    input  logic             tlp_done,
    input  logic             rd_cpl_done,
    output logic [CNT_W-1:0] outstanding_rd,
    output logic             credit_err,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_ACK       = 2'd3;

    // Requester IDs double as the tlp_kind encoding.
    localparam logic [1:0] REQ_RD  = 2'd0;
    localparam logic [1:0] REQ_NTF = 2'd1;
    localparam logic [1:0] REQ_IRQ = 2'd2;

    logic [1:0] state;
    logic [1:0] grant;
    logic [1:0] rr_last;
    logic       rd_elig;
    logic       any_elig;
    logic [1:0] winner;
    logic       cnt_inc;
    logic       cnt_dec;

    assign rd_elig  = rd_req && (outstanding_rd < CNT_W'(MAX_RD_OUTSTANDING));
    assign any_elig = rd_elig || ntf_req || irq_req;

    // Round-robin pick: search starts at the requester after the last grant.
    always_comb begin
        winner = REQ_RD;
        case (rr_last)
            REQ_RD: begin
                if (ntf_req)      winner = REQ_NTF;
                else if (irq_req) winner = REQ_IRQ;
                else              winner = REQ_RD;
            end
            REQ_NTF: begin
                if (irq_req)      winner = REQ_IRQ;
                else if (rd_elig) winner = REQ_RD;
                else              winner = REQ_NTF;
            end
            default: begin
                if (rd_elig)      winner = REQ_RD;
                else if (ntf_req) winner = REQ_NTF;
                else              winner = REQ_IRQ;
            end
        endcase
    end

    // Grant / issue / wait-for-done / ack sequencing and request latching.
    always_ff @(posedge trn_clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            grant      <= REQ_RD;
            rr_last    <= REQ_IRQ;
            tlp_start  <= 1'b0;
            tlp_kind   <= '0;
            tlp_addr   <= '0;
            tlp_qwords <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_elig) begin
                        grant      <= winner;
                        rr_last    <= winner;
                        tlp_kind   <= winner;
                        tlp_addr   <= (winner == REQ_RD) ? rd_addr : '0;
                        tlp_qwords <= (winner == REQ_RD) ? rd_qwords : '0;
                        tlp_start  <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (tlp_start_ack) begin
                        tlp_start <= 1'b0;
                        state     <= tlp_done ? ST_ACK : ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tlp_done) state <= ST_ACK;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Acks are decoded from the ACK state, so each is a single-cycle pulse.
    assign rd_ack  = (state == ST_ACK) && (grant == REQ_RD);
    assign ntf_ack = (state == ST_ACK) && (grant == REQ_NTF);
    assign irq_ack = (state == ST_ACK) && (grant == REQ_IRQ);
    assign busy    = (state != ST_IDLE);

    assign cnt_inc = rd_ack;
    assign cnt_dec = rd_cpl_done;

    // Outstanding-read credit counter with sticky underflow flag.
    always_ff @(posedge trn_clk) begin
        if (!reset_n) begin
            outstanding_rd <= '0;
            credit_err     <= 1'b0;
        end else if (cnt_inc && !cnt_dec) begin
            outstanding_rd <= outstanding_rd + CNT_W'(1);
        end else if (cnt_dec && !cnt_inc) begin
            if (outstanding_rd == '0) credit_err <= 1'b1;
            else                      outstanding_rd <= outstanding_rd - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tx_tlp_req_arbiter.sv
// Self-checking bench for tx_tlp_req_arbiter: table of single transactions
// from reset plus hand-written multi-cycle sequences, with a scoreboard of
// expected grants.
module tb_tx_tlp_req_arbiter;

    logic        trn_clk = 1'b0;
    logic        reset_n;
    logic        rd_req;
    logic [63:0] rd_addr;
    logic [8:0]  rd_qwords;
    logic        rd_ack;
    logic        ntf_req;
    logic        ntf_ack;
    logic        irq_req;
    logic        irq_ack;
    logic        tlp_start;
    logic [1:0]  tlp_kind;
    logic [63:0] tlp_addr;
    logic [8:0]  tlp_qwords;
    logic        tlp_start_ack;
    logic        tlp_done;
    logic        rd_cpl_done;
    logic [3:0]  outstanding_rd;
    logic        credit_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [1:0]  kind;
        logic [63:0] addr;
        logic [8:0]  qw;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        ntf;
        logic        irq;
        logic [63:0] addr;
        logic [8:0]  qw;
        int          ack_dly;
        int          done_dly;
        logic [1:0]  exp_kind;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    tx_tlp_req_arbiter #(
        .MAX_RD_OUTSTANDING(8),
        .CNT_W(4)
    ) dut (
        .trn_clk(trn_clk),
        .reset_n(reset_n),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_qwords(rd_qwords),
        .rd_ack(rd_ack),
        .ntf_req(ntf_req),
        .ntf_ack(ntf_ack),
        .irq_req(irq_req),
        .irq_ack(irq_ack),
        .tlp_start(tlp_start),
        .tlp_kind(tlp_kind),
        .tlp_addr(tlp_addr),
        .tlp_qwords(tlp_qwords),
        .tlp_start_ack(tlp_start_ack),
        .tlp_done(tlp_done),
        .rd_cpl_done(rd_cpl_done),
        .outstanding_rd(outstanding_rd),
        .credit_err(credit_err),
        .busy(busy)
    );

    always #2 trn_clk = ~trn_clk;

    task automatic tick();
        @(posedge trn_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [63:0] addr, input logic [8:0] qw);
        exp_t e;
        e.kind = kind;
        e.addr = (kind == 2'd0) ? addr : 64'd0;
        e.qw   = (kind == 2'd0) ? qw : 9'd0;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        rd_req        = 1'b0;
        ntf_req       = 1'b0;
        irq_req       = 1'b0;
        rd_addr       = 64'd0;
        rd_qwords     = 9'd0;
        tlp_start_ack = 1'b0;
        tlp_done      = 1'b0;
        rd_cpl_done   = 1'b0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(tlp_start), 64'd0);
        check("rst_cnt", 64'(outstanding_rd), 64'd0);
        check("rst_err", 64'(credit_err), 64'd0);
        check("rst_acks", 64'({rd_ack, ntf_ack, irq_ack}), 64'd0);
        check("rst_tlp", 64'(tlp_addr) | 64'(tlp_qwords) | 64'(tlp_kind), 64'd0);
        reset_n = 1'b1;
        sb_q.delete();
        exp_cnt = 0;
    endtask

    // Wait for a grant, compare it to the scoreboard, play the formatter
    // (start_ack after ack_dly, done after done_dly cycles) and check the ack.
    task automatic run_txn(input int ack_dly, input int done_dly, input bit keep, input bit cpl);
        int   n;
        exp_t e;
        tick();
        n = 1;
        while (tlp_start !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        if (tlp_start !== 1'b1) begin
            check("start_timeout", 64'(tlp_start), 64'd1);
            return;
        end
        check("start_latency", 64'(n), 64'd1);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty act=grant exp=none at %0t", $time);
            return;
        end
        e = sb_q.pop_front();
        for (int c = 0; c <= done_dly; c++) begin
            tlp_start_ack = (c == ack_dly);
            tlp_done      = (c == done_dly);
            check("tlp_start", 64'(tlp_start), 64'(c <= ack_dly));
            check("tlp_kind", 64'(tlp_kind), 64'(e.kind));
            check("tlp_addr", tlp_addr, e.addr);
            check("tlp_qwords", 64'(tlp_qwords), 64'(e.qw));
            check("busy_txn", 64'(busy), 64'd1);
            tick();
        end
        tlp_start_ack = 1'b0;
        tlp_done      = 1'b0;
        check("rd_ack", 64'(rd_ack), 64'(e.kind == 2'd0));
        check("ntf_ack", 64'(ntf_ack), 64'(e.kind == 2'd1));
        check("irq_ack", 64'(irq_ack), 64'(e.kind == 2'd2));
        check("start_in_ack", 64'(tlp_start), 64'd0);
        if (cpl) rd_cpl_done = 1'b1;
        if (!keep) begin
            case (e.kind)
                2'd0:    rd_req = 1'b0;
                2'd1:    ntf_req = 1'b0;
                default: irq_req = 1'b0;
            endcase
        end
        tick();
        rd_cpl_done = 1'b0;
        check("acks_after", 64'({rd_ack, ntf_ack, irq_ack}), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        if (e.kind == 2'd0 && !cpl) exp_cnt++;
        check("outstanding", 64'(outstanding_rd), 64'(exp_cnt));
    endtask

    task automatic cpl_pulse();
        rd_cpl_done = 1'b1;
        tick();
        rd_cpl_done = 1'b0;
    endtask

    // Never more than one ack in any cycle.
    always @(negedge trn_clk) begin
        if (reset_n === 1'b1)
            check("ack_onehot", 64'($countones({rd_ack, ntf_ack, irq_ack}) > 1), 64'd0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 64'h0000_0001_0000_0200, 9'h040, 2, 5, 2'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_1000, 9'd7,   0, 0, 2'd1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 9'd3,   1, 3, 2'd2};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 9'd1,   0, 2, 2'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_0040, 9'd9,   3, 3, 2'd1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 64'h0000_00AB_CDEF_0008, 9'd64,  1, 1, 2'd0};

        // Single transactions from reset: rd > ntf > irq priority after reset.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            rd_addr   = vecs[i].addr;
            rd_qwords = vecs[i].qw;
            rd_req    = vecs[i].rd;
            ntf_req   = vecs[i].ntf;
            irq_req   = vecs[i].irq;
            push_exp(vecs[i].exp_kind, vecs[i].addr, vecs[i].qw);
            run_txn(vecs[i].ack_dly, vecs[i].done_dly, 1'b0, 1'b0);
            rd_req  = 1'b0;
            ntf_req = 1'b0;
            irq_req = 1'b0;
        end

        // Round-robin with all requesters held high.
        do_reset();
        rd_addr   = 64'h0000_0002_0000_0000;
        rd_qwords = 9'd16;
        rd_req    = 1'b1;
        ntf_req   = 1'b1;
        irq_req   = 1'b1;
        for (int i = 0; i < 6; i++) push_exp(2'(i % 3), rd_addr, rd_qwords);
        for (int i = 0; i < 6; i++) run_txn(0, 0, 1'b1, 1'b0);
        rd_req  = 1'b0;
        ntf_req = 1'b0;
        irq_req = 1'b0;

        // Credit limit: 8 reads fill the counter, irq still served.
        do_reset();
        rd_addr   = 64'h0000_0003_0000_0100;
        rd_qwords = 9'd32;
        rd_req    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_exp(2'd0, rd_addr, rd_qwords);
            run_txn(0, 1, 1'b1, 1'b0);
        end
        check("cnt_full", 64'(outstanding_rd), 64'd8);
        irq_req = 1'b1;
        push_exp(2'd2, rd_addr, rd_qwords);
        run_txn(0, 1, 1'b0, 1'b0);
        repeat (3) tick();
        check("rd_blocked_start", 64'(tlp_start), 64'd0);
        check("rd_blocked_busy", 64'(busy), 64'd0);
        push_exp(2'd0, rd_addr, rd_qwords);
        cpl_pulse();
        exp_cnt--;
        check("cnt_after_cpl", 64'(outstanding_rd), 64'd7);
        run_txn(0, 1, 1'b0, 1'b0);
        check("cnt_refull", 64'(outstanding_rd), 64'd8);

        // Simultaneous increment/decrement, then underflow.
        do_reset();
        rd_addr   = 64'h0000_0004_0000_0000;
        rd_qwords = 9'd8;
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1;
            push_exp(2'd0, rd_addr, rd_qwords);
            run_txn(1, 2, 1'b0, 1'b0);
        end
        rd_req = 1'b1;
        push_exp(2'd0, rd_addr, rd_qwords);
        run_txn(0, 2, 1'b0, 1'b1);
        check("cnt_simul", 64'(outstanding_rd), 64'd3);
        for (int i = 0; i < 3; i++) begin
            cpl_pulse();
            exp_cnt--;
            check("cnt_dec", 64'(outstanding_rd), 64'(exp_cnt));
            check("err_clear", 64'(credit_err), 64'd0);
        end
        cpl_pulse();
        check("cnt_underflow", 64'(outstanding_rd), 64'd0);
        check("err_set", 64'(credit_err), 64'd1);
        repeat (100) tick();
        check("err_sticky", 64'(credit_err), 64'd1);
        check("cnt_stays0", 64'(outstanding_rd), 64'd0);

        // Reset in WAIT_DONE with count 5.
        do_reset();
        rd_addr   = 64'h0000_0005_0000_0040;
        rd_qwords = 9'd2;
        for (int i = 0; i < 5; i++) begin
            rd_req = 1'b1;
            push_exp(2'd0, rd_addr, rd_qwords);
            run_txn(0, 1, 1'b0, 1'b0);
        end
        check("cnt_five", 64'(outstanding_rd), 64'd5);
        rd_req = 1'b1;
        tick();
        check("mid_start", 64'(tlp_start), 64'd1);
        tlp_start_ack = 1'b1;
        tick();
        tlp_start_ack = 1'b0;
        check("mid_wait_busy", 64'(busy), 64'd1);
        check("mid_wait_start", 64'(tlp_start), 64'd0);
        reset_n = 1'b0;
        ntf_req = 1'b1;
        irq_req = 1'b1;
        tick();
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_start", 64'(tlp_start), 64'd0);
        check("mid_rst_cnt", 64'(outstanding_rd), 64'd0);
        check("mid_rst_acks", 64'({rd_ack, ntf_ack, irq_ack}), 64'd0);
        check("mid_rst_tlp", tlp_addr | 64'(tlp_kind) | 64'(tlp_qwords), 64'd0);
        reset_n = 1'b1;
        sb_q.delete();
        exp_cnt = 0;
        push_exp(2'd0, rd_addr, rd_qwords);
        run_txn(0, 1, 1'b0, 1'b0);
        rd_req  = 1'b0;
        ntf_req = 1'b0;
        irq_req = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_tlp_req_arbiter.md
Name: tx_tlp_req_arbiter

Overview:
Arbitrates the three TX-side requesters of the host-to-card engine (chunk read request, huge-page-read-completed notification, interrupt) onto the single TLP formatter port. It also limits in-flight memory reads with an outstanding-read credit counter, which decrements when each read's completion data has landed in BRAM. The block sits between the BRAM-fill logic and the TX TLP formatter, in the trn_clk domain.

Parameters:
MAX_RD_OUTSTANDING, 8, max granted-but-uncompleted chunk reads (1..15)
CNT_W, 4, width of outstanding-read counter

Ports:
trn_clk  in  1  TRN clock (250 MHz)
reset_n  in  1  synchronous active-low reset
rd_req  in  1  chunk read request, level, held until rd_ack
rd_addr  in  64  host address of chunk, stable while rd_req=1
rd_qwords  in  9  qwords to read (1..64), stable while rd_req=1
rd_ack  out  1  one-cycle pulse: read TLP sent
ntf_req  in  1  huge-page-read-completed notification request, level
ntf_ack  out  1  one-cycle pulse: notification sent
irq_req  in  1  interrupt request, level
irq_ack  out  1  one-cycle pulse: interrupt sent
tlp_start  out  1  request to formatter, held until tlp_start_ack
tlp_kind  out  2  00 rd, 01 ntf, 10 irq, 11 unused
tlp_addr  out  64  latched rd_addr (0 for ntf/irq)
tlp_qwords  out  9  latched rd_qwords (0 for ntf/irq)
tlp_start_ack  in  1  formatter accepted request (pulse)
tlp_done  in  1  formatter finished sending TLP (pulse)
rd_cpl_done  in  1  pulse: all completion data for one chunk read written to BRAM
outstanding_rd  out  CNT_W  current in-flight read count
credit_err  out  1  sticky: rd_cpl_done seen with outstanding_rd=0
busy  out  1  FSM not in IDLE

Behaviour:
- All state is updated on trn_clk rising edge. reset_n=0 at any edge, including mid-transaction, has these effects:
  - FSM goes to IDLE.
  - All outputs go to 0, including outstanding_rd, credit_err and tlp_addr/tlp_qwords/tlp_kind.
  - The round-robin pointer goes to irq, so rd has first priority after reset.
- Eligibility: rd is eligible iff rd_req=1 and outstanding_rd < MAX_RD_OUTSTANDING. ntf and irq are eligible iff their req=1.
- Round-robin order rd→ntf→irq→rd. The search starts at the requester after the last granted one. The pointer updates only on grant.
- FSM:
  - IDLE: if any requester is eligible, grant the winner. Latch tlp_kind/tlp_addr/tlp_qwords, set tlp_start=1, go to ISSUE. If no requester is eligible, stay in IDLE.
  - ISSUE: hold tlp_start and the tlp_* outputs stable.
    - On tlp_start_ack: drop tlp_start next edge. Go to WAIT_DONE, or to ACK if tlp_done is also 1 in the same cycle.
  - WAIT_DONE: on tlp_done, go to ACK.
  - ACK: pulse the granted requester's ack for exactly one cycle, then go to IDLE.
    - If granted=rd, outstanding_rd increments on this edge.
- Latency:
  - Request seen in IDLE at cycle N → tlp_start=1 at N+1.
  - tlp_done at cycle M → ack=1 at M+1 → IDLE at M+2.
  - The requester deasserts its req on the edge after ack, so IDLE never re-grants a stale request.
- Only one grant is active at a time; only one ack is high in any cycle.
- Counter rules:
  - ACK(rd) with no rd_cpl_done: +1.
  - rd_cpl_done alone: −1.
  - Both in the same cycle: unchanged.
  - rd_cpl_done when the count is 0 (and no simultaneous increment): count stays 0 and credit_err←1 (sticky until reset).
  - The counter never exceeds MAX_RD_OUTSTANDING, because rd is ineligible at the limit.
- Credit-full: while rd is blocked by credits, ntf/irq are still granted. rd is granted the first IDLE cycle after the count drops below the limit, subject to the round-robin pointer.
- tlp_start_ack or tlp_done outside the expected state is ignored. A request deasserted before its ack is a protocol violation; the arbiter completes the transaction regardless.
- busy=1 in ISSUE, WAIT_DONE and ACK.

Test Plan:
- Single rd: rd_req with addr 0x0000_0001_0000_0200, qwords 0x40; formatter acks 2 cycles later and tlp_done 5 cycles later → tlp_kind=00 with addr/qwords latched; rd_ack is a 1-cycle pulse the cycle after tlp_done; outstanding_rd=1.
- Round-robin: rd, ntf and irq all held high from reset; each granted TLP is acked immediately → grant order rd, ntf, irq, rd…; exactly one ack per transaction and never two acks in the same cycle.
- Credit limit (MAX=8): issue 8 rd grants with no rd_cpl_done → outstanding_rd=8 and rd_req stays pending; irq_req is still served; a single rd_cpl_done → count 7, rd is granted next IDLE, count back to 8.
- Simultaneous: rd ACK cycle coincides with rd_cpl_done at count 3 → count stays 3. rd_cpl_done at count 0 → credit_err=1, count 0, and credit_err still 1 after 100 cycles.
- Same-cycle start_ack+done in ISSUE → ACK the next cycle (start to ack in 3 cycles total), and tlp_start is low in ACK.
- Reset mid-op: assert reset_n=0 while in WAIT_DONE with count 5 → after the edge, busy=0, tlp_start=0, outstanding_rd=0, no ack pulse; the first grant after release is rd if rd is requesting.
